// File: rtl/user_input_device.sv
// user_input_device: Avalon-MM slave front end for board push-buttons and slide
// switches. Both banks are sampled every clock, a sticky level interrupt is
// raised on any change, and the interrupt is cleared when the CPU reads the
// current input state.
module user_input_device #(
    parameter int unsigned NUM_KEYS     = 4,
    parameter int unsigned NUM_SWITCHES = 4
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [NUM_KEYS-1:0]              keys,
    input  logic [NUM_SWITCHES-1:0]          switches,
    input  logic                             avl_read,
    output logic [NUM_SWITCHES+NUM_KEYS-1:0] avl_readdata,
    output logic                             avl_irq
);

    localparam int unsigned W = NUM_SWITCHES + NUM_KEYS;

    // Idle pin levels: buttons released (high), switches off (low).
    localparam logic [W-1:0] IDLE_VAL = {{NUM_SWITCHES{1'b0}}, {NUM_KEYS{1'b1}}};

    // Packed as {switches, keys}; keys occupy the LSBs.
    logic [W-1:0] sample_q;
    logic [W-1:0] state_q;
    logic         irq_q;
    logic         irq_d;
    logic         change;

    // Stage 1 doubles as the synchronizer for the asynchronous pins.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sample_q <= IDLE_VAL;
        end else begin
            sample_q <= {switches, keys};
        end
    end

    // Stage 2 holds the last-seen state that software reads back.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE_VAL;
        end else begin
            state_q <= sample_q;
        end
    end

    // Any difference between the two stages is a fresh input event.
    always_comb begin
        change = (sample_q != state_q);
    end

    // Interrupt next state: a change beats a read so no event is lost.
    always_comb begin
        irq_d = irq_q;
        if (change) begin
            irq_d = 1'b1;
        end else if (avl_read) begin
            irq_d = 1'b0;
        end
    end

    // Sticky interrupt flag; reset drops it immediately.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            irq_q <= 1'b0;
        end else begin
            irq_q <= irq_d;
        end
    end

    // Zero-wait-state read data; keys inverted so 1 means pressed.
    always_comb begin
        avl_readdata = {state_q[W-1:NUM_KEYS], ~state_q[NUM_KEYS-1:0]};
        avl_irq      = irq_q;
    end

endmodule

// File: tb/tb_user_input_device.sv
// Directed bench for user_input_device with a read-data scoreboard.
module tb_user_input_device;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [3:0] keys = 4'b1111;
    logic [3:0] switches = 4'b0000;
    logic       avl_read = 1'b0;
    logic [7:0] avl_readdata;
    logic       avl_irq;

    int checks = 0;
    int errors = 0;
    logic [7:0] exp_q[$];

    user_input_device #(
        .NUM_KEYS    (4),
        .NUM_SWITCHES(4)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .keys        (keys),
        .switches    (switches),
        .avl_read    (avl_read),
        .avl_readdata(avl_readdata),
        .avl_irq     (avl_irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; waits at most two edges for the interrupt.
    task automatic wait_irq(input string tag);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < 2; i++) begin
            if (!seen) begin
                @(posedge clk);
                @(negedge clk);
                if (avl_irq === 1'b1) seen = 1'b1;
            end
        end
        check(tag, {7'd0, avl_irq}, 8'd1);
    endtask

    // Called at a negedge; one-cycle read, returns at the following negedge.
    task automatic do_read(input string tag, input logic [7:0] exp_data);
        logic [7:0] e;
        exp_q.push_back(exp_data);
        avl_read = 1'b1;
        #1;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL %s: scoreboard empty", tag);
        end else begin
            e = exp_q.pop_front();
            check(tag, avl_readdata, e);
        end
        @(posedge clk);
        @(negedge clk);
        avl_read = 1'b0;
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    initial begin
        // Reset with idle pins.
        #12;
        check("irq_in_reset", {7'd0, avl_irq}, 8'd0);
        check("rdata_in_reset", avl_readdata, 8'h00);
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("irq_idle_after_reset", {7'd0, avl_irq}, 8'd0);
        end
        check("rdata_idle", avl_readdata, 8'h00);

        // Switch 0 on, then off.
        switches = 4'b0001;
        wait_irq("irq_sw0_on");
        do_read("rdata_sw0_on", 8'h10);
        check("irq_clr_sw0_on", {7'd0, avl_irq}, 8'd0);

        switches = 4'b0000;
        wait_irq("irq_sw0_off");
        do_read("rdata_sw0_off", 8'h00);
        check("irq_clr_sw0_off", {7'd0, avl_irq}, 8'd0);

        // Key 1 pressed, then released.
        keys = 4'b1101;
        wait_irq("irq_key1_press");
        do_read("rdata_key1_press", 8'h02);
        check("irq_clr_key1_press", {7'd0, avl_irq}, 8'd0);

        keys = 4'b1111;
        wait_irq("irq_key1_rel");
        do_read("rdata_key1_rel", 8'h00);
        check("irq_clr_key1_rel", {7'd0, avl_irq}, 8'd0);

        // Read in the cycle where the change is detected: change wins.
        switches = 4'b0010;
        @(posedge clk);
        @(negedge clk);
        do_read("rdata_collide_old", 8'h00);
        check("irq_collide_held", {7'd0, avl_irq}, 8'd1);
        do_read("rdata_collide_new", 8'h20);
        check("irq_collide_clr", {7'd0, avl_irq}, 8'd0);

        // Idle read has no side effect.
        do_read("rdata_idle_read", 8'h20);
        check("irq_idle_read", {7'd0, avl_irq}, 8'd0);
        cycles(2);
        check("irq_idle_hold", {7'd0, avl_irq}, 8'd0);

        // Change that reverts before the read still leaves irq set.
        switches = 4'b0011;
        @(negedge clk);
        switches = 4'b0010;
        cycles(4);
        check("irq_revert", {7'd0, avl_irq}, 8'd1);
        do_read("rdata_revert", 8'h20);
        check("irq_clr_revert", {7'd0, avl_irq}, 8'd0);

        // Single-cycle key pulse is captured.
        keys = 4'b1110;
        @(negedge clk);
        keys = 4'b1111;
        cycles(4);
        check("irq_pulse", {7'd0, avl_irq}, 8'd1);
        do_read("rdata_pulse", 8'h20);
        check("irq_clr_pulse", {7'd0, avl_irq}, 8'd0);

        // Reset while irq is set drops it without a clock edge.
        switches = 4'b0100;
        wait_irq("irq_before_reset");
        #2;
        reset = 1'b0;
        #1;
        check("irq_async_reset", {7'd0, avl_irq}, 8'd0);
        check("rdata_async_reset", avl_readdata, 8'h00);
        @(negedge clk);
        reset = 1'b1;
        wait_irq("irq_after_release");
        do_read("rdata_after_release", 8'h40);
        check("irq_clr_after_release", {7'd0, avl_irq}, 8'd0);

        check("scoreboard_drained", 8'(exp_q.size()), 8'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Absolute time bound so the run always ends.
    initial begin
        #20000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
